// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_stage_pkg;

  localparam int unsigned WordLength     = 32;
  localparam int unsigned MaxOutstanding = 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} fetch_state_e;

  localparam logic [1:0] TrapNone  = 2'b00;
  localparam logic [1:0] TrapIacc  = 2'b01;
  localparam logic [1:0] TrapAlign = 2'b10;

  // pstate0 carries the segment as a whole word; pstate1 is the byte offset.
  localparam int unsigned OfsAlignMsb = 1;
  localparam int unsigned OfsAlignLsb = 0;

  function automatic logic is_misaligned(input logic [OfsAlignMsb:OfsAlignLsb] low_bits);
    return low_bits != '0;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_out_reg.sv
// Decode-side output register: loads a bundle, holds it while decode stalls, drops it on flush.
module instr_fetch_stage_out_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             ready_i,
  input  logic [Width-1:0] instr_i,
  input  logic [Width-1:0] pstate0_i,
  input  logic [Width-1:0] pstate1_i,
  input  logic [1:0]       trap_i,
  output logic             valid_o,
  output logic [Width-1:0] instr_o,
  output logic [Width-1:0] pstate0_o,
  output logic [Width-1:0] pstate1_o,
  output logic [1:0]       trap_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o   <= 1'b0;
      instr_o   <= '0;
      pstate0_o <= '0;
      pstate1_o <= '0;
      trap_o    <= '0;
    end else begin
      // A new bundle wins over consumption of the old one in the same cycle.
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (load_i) begin
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      if (load_i && !flush_i) begin
        instr_o   <= instr_i;
        pstate0_o <= pstate0_i;
        pstate1_o <= pstate1_i;
        trap_o    <= trap_i;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch half of the FD stage: latch an address, issue one I-cache read, present the word to decode.
// Define VCPU32_FETCH_ALIGN_CHECK_EN to trap misaligned offsets instead of masking them.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WordLength
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGTH-1:0] iaPstate0,
  input  logic [WORD_LENGTH-1:0] iaPstate1,
  input  logic                   iaValid,
  output logic                   iaReady,
  output logic                   icReqValid,
  input  logic                   icReqReady,
  output logic [WORD_LENGTH-1:0] icReqSeg,
  output logic [WORD_LENGTH-1:0] icReqOfs,
  input  logic                   icRspValid,
  input  logic [WORD_LENGTH-1:0] icRspData,
  input  logic                   icRspErr,
  input  logic                   flush,
  input  logic                   fdReady,
  output logic                   fdValid,
  output logic [WORD_LENGTH-1:0] fdInstr,
  output logic [WORD_LENGTH-1:0] fdPstate0,
  output logic [WORD_LENGTH-1:0] fdPstate1,
  output logic [1:0]             fdTrap
);

  fetch_state_e           state_q, state_d;
  logic [WORD_LENGTH-1:0] seg_q, seg_d;
  logic [WORD_LENGTH-1:0] ofs_q, ofs_d;
  logic                   kill_q, kill_d;

  logic                   accept;
  logic                   misaligned;
  logic                   rsp_live;
  logic                   out_load;
  logic [WORD_LENGTH-1:0] load_instr;
  logic [WORD_LENGTH-1:0] load_p0;
  logic [WORD_LENGTH-1:0] load_p1;
  logic [1:0]             load_trap;

  // A killed request must drain its response before a new one may be issued.
  assign iaReady    = !flush && ((state_q == StIdle && !kill_q) || (state_q == StOut && fdReady));
  assign accept     = iaValid && iaReady;
  assign icReqValid = (state_q == StReq);
  assign icReqSeg   = seg_q;

`ifdef VCPU32_FETCH_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(iaPstate1[OfsAlignMsb:OfsAlignLsb]);
  assign icReqOfs   = ofs_q;
`else
  assign misaligned = 1'b0;
  assign icReqOfs   = ofs_q & ~WORD_LENGTH'(2'b11);
`endif

  assign rsp_live   = icRspValid && (state_q == StWait) && !flush;
  assign out_load   = rsp_live || (accept && misaligned);
  assign load_instr = (rsp_live && !icRspErr) ? icRspData : '0;
  assign load_p0    = rsp_live ? seg_q : iaPstate0;
  assign load_p1    = rsp_live ? ofs_q : iaPstate1;
  assign load_trap  = rsp_live ? (icRspErr ? TrapIacc : TrapNone) : TrapAlign;

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    ofs_d   = ofs_q;
    kill_d  = kill_q;
    if (kill_q && icRspValid) kill_d = 1'b0;
    if (accept) begin
      seg_d = iaPstate0;
      ofs_d = iaPstate1;
    end
    unique case (state_q)
      StIdle:  if (accept) state_d = misaligned ? StOut : StReq;
      StReq:   if (icReqReady) state_d = StWait;
      StWait:  if (icRspValid) state_d = StOut;
      StOut:   if (fdReady) state_d = accept ? (misaligned ? StOut : StReq) : StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      if ((state_q == StWait && !icRspValid) || (state_q == StReq && icReqReady)) kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      seg_q   <= '0;
      ofs_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      ofs_q   <= ofs_d;
      kill_q  <= kill_d;
    end
  end

  instr_fetch_stage_out_reg #(
    .Width (WORD_LENGTH)
  ) u_out_reg (
    .clk_i     (clk),
    .rst_ni    (rst),
    .flush_i   (flush),
    .load_i    (out_load),
    .ready_i   (fdReady),
    .instr_i   (load_instr),
    .pstate0_i (load_p0),
    .pstate1_i (load_p1),
    .trap_i    (load_trap),
    .valid_o   (fdValid),
    .instr_o   (fdInstr),
    .pstate0_o (fdPstate0),
    .pstate1_o (fdPstate1),
    .trap_o    (fdTrap)
  );

`ifndef SYNTHESIS
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    !(icRspValid && state_q != StWait && !kill_q));
  a_one_outstanding: assert property (@(posedge clk) disable iff (!rst)
    (int'(kill_q) + int'(state_q == StWait)) <= int'(MaxOutstanding));
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: vector table, directed corner cases, random vs model.
module tb_instr_fetch_stage;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] iaPstate0, iaPstate1;
  logic         iaValid, iaReady;
  logic         icReqValid, icReqReady;
  logic [W-1:0] icReqSeg, icReqOfs;
  logic         icRspValid;
  logic [W-1:0] icRspData;
  logic         icRspErr;
  logic         flush, fdReady, fdValid;
  logic [W-1:0] fdInstr, fdPstate0, fdPstate1;
  logic [1:0]   fdTrap;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int leak_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .iaPstate0  (iaPstate0),
    .iaPstate1  (iaPstate1),
    .iaValid    (iaValid),
    .iaReady    (iaReady),
    .icReqValid (icReqValid),
    .icReqReady (icReqReady),
    .icReqSeg   (icReqSeg),
    .icReqOfs   (icReqOfs),
    .icRspValid (icRspValid),
    .icRspData  (icRspData),
    .icRspErr   (icRspErr),
    .flush      (flush),
    .fdReady    (fdReady),
    .fdValid    (fdValid),
    .fdInstr    (fdInstr),
    .fdPstate0  (fdPstate0),
    .fdPstate1  (fdPstate1),
    .fdTrap     (fdTrap)
  );

  always @(posedge clk) begin
    if (rst && icReqValid && icReqReady) hs_cnt <= hs_cnt + 1;
    if (fdValid && fdInstr == 32'h1111_1111) leak_cnt <= leak_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    iaValid = 1'b0; iaPstate0 = '0; iaPstate1 = '0;
    icReqReady = 1'b0; icRspValid = 1'b0; icRspData = '0; icRspErr = 1'b0;
    flush = 1'b0; fdReady = 1'b1;
  endtask

  typedef struct {
    logic         ia_valid;
    logic [W-1:0] p0, p1;
    logic         req_rdy, rsp_valid, rsp_err;
    logic [W-1:0] rsp_data;
    logic         flush, fd_rdy;
    logic         e_ia_rdy, e_req_valid;
    logic [W-1:0] e_ofs;
    logic         e_fd_valid;
    logic [W-1:0] e_instr, e_p1;
    logic [1:0]   e_trap;
  } vec_t;

  vec_t vecs[11];

  // Reference model state: address waiting to be requested, live/dead request, output bundle.
  logic         m_have_addr, m_in_flight, m_orphan, m_out_valid;
  logic [W-1:0] m_seg, m_ofs, m_instr, m_p0, m_p1;
  logic [1:0]   m_trap;
  int           pend;

  initial begin
    logic         exp_rdy, acc, hs, mis;
    logic [W-1:0] r;
    logic         n_have, n_in, n_orph, n_outv;
    int           hs0;

    defaults();
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    #1;
    check("rst iaReady", iaReady, 1);
    check("rst icReqValid", icReqValid, 0);
    check("rst fdValid", fdValid, 0);
    check("rst fdInstr", fdInstr, 0);
    check("rst fdPstate0", fdPstate0, 0);
    check("rst fdPstate1", fdPstate1, 0);
    check("rst fdTrap", fdTrap, 0);
    check("rst icReqSeg", icReqSeg, 0);
    check("rst icReqOfs", icReqOfs, 0);

    vecs[0]  = '{1, 32'hA5, 32'h1000, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 2'd0};
    vecs[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 1, 32'h1000, 0, 0, 0, 2'd0};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 1,  0, 0, 32'h1000, 0, 0, 0, 2'd0};
    vecs[3]  = '{1, 32'hB6, 32'h1004, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h1000, 1, 32'hDEADBEEF, 32'h1000, 2'd0};
    vecs[4]  = '{1, 32'hB6, 32'h1004, 0, 0, 0, 0, 0, 1,
                 1, 0, 32'h1000, 1, 32'hDEADBEEF, 32'h1000, 2'd0};
    vecs[5]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 1, 32'h1004, 0, 32'hDEADBEEF, 32'h1000, 2'd0};
    vecs[6]  = '{0, 0, 0, 0, 1, 1, 32'h12345678, 0, 1,
                 0, 0, 32'h1004, 0, 32'hDEADBEEF, 32'h1000, 2'd0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 32'h1004, 1, 0, 32'h1004, 2'd1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 32'h1004, 0, 0, 32'h1004, 2'd1};
    vecs[9]  = '{1, 0, 32'h3000, 1, 0, 0, 0, 1, 1,  0, 0, 32'h1004, 0, 0, 32'h1004, 2'd1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 32'h1004, 0, 0, 32'h1004, 2'd1};

    for (int i = 0; i < 11; i++) begin
      iaValid = vecs[i].ia_valid; iaPstate0 = vecs[i].p0; iaPstate1 = vecs[i].p1;
      icReqReady = vecs[i].req_rdy; icRspValid = vecs[i].rsp_valid;
      icRspErr = vecs[i].rsp_err; icRspData = vecs[i].rsp_data;
      flush = vecs[i].flush; fdReady = vecs[i].fd_rdy;
      #1;
      check($sformatf("vec%0d iaReady", i), iaReady, vecs[i].e_ia_rdy);
      check($sformatf("vec%0d icReqValid", i), icReqValid, vecs[i].e_req_valid);
      check($sformatf("vec%0d icReqOfs", i), icReqOfs, vecs[i].e_ofs);
      check($sformatf("vec%0d fdValid", i), fdValid, vecs[i].e_fd_valid);
      check($sformatf("vec%0d fdInstr", i), fdInstr, vecs[i].e_instr);
      check($sformatf("vec%0d fdPstate1", i), fdPstate1, vecs[i].e_p1);
      check($sformatf("vec%0d fdTrap", i), fdTrap, vecs[i].e_trap);
      cycle();
    end
    defaults();

    // Decode stall, then release with a same-cycle accept.
    fdReady = 1'b0;
    iaValid = 1'b1; iaPstate0 = 32'h77; iaPstate1 = 32'h4000; cycle();
    iaValid = 1'b0; icReqReady = 1'b1; cycle();
    icReqReady = 1'b0; icRspValid = 1'b1; icRspData = 32'hCAFEF00D; cycle();
    icRspValid = 1'b0;
    iaValid = 1'b1; iaPstate0 = 32'h78; iaPstate1 = 32'h4010;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall fdValid", fdValid, 1);
      check("stall fdInstr", fdInstr, 32'hCAFEF00D);
      check("stall fdPstate1", fdPstate1, 32'h4000);
      check("stall iaReady", iaReady, 0);
      cycle();
    end
    fdReady = 1'b1;
    #1;
    check("release iaReady", iaReady, 1);
    cycle();
    iaValid = 1'b0;
    check("release icReqValid", icReqValid, 1);
    check("release icReqOfs", icReqOfs, 32'h4010);
    check("release fdValid", fdValid, 0);

    // Cache miss: slow request acceptance and a slow response.
    hs0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("miss icReqValid", icReqValid, 1);
      check("miss icReqOfs", icReqOfs, 32'h4010);
      cycle();
    end
    icReqReady = 1'b1; cycle();
    icReqReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("miss wait icReqValid", icReqValid, 0);
      check("miss wait fdValid", fdValid, 0);
      check("miss wait icReqOfs", icReqOfs, 32'h4010);
      cycle();
    end
    icRspValid = 1'b1; icRspData = 32'h0BADC0DE; cycle();
    icRspValid = 1'b0;
    check("miss fdValid", fdValid, 1);
    check("miss fdInstr", fdInstr, 32'h0BADC0DE);
    check("miss fdPstate0", fdPstate0, 32'h78);
    check("miss fdPstate1", fdPstate1, 32'h4010);
    check("miss handshakes", hs_cnt - hs0, 1);
    cycle();

    // Flush in WAIT: the late response must be swallowed.
    iaValid = 1'b1; iaPstate0 = 32'h98; iaPstate1 = 32'h1800; cycle();
    iaValid = 1'b0; icReqReady = 1'b1; cycle();
    icReqReady = 1'b0; flush = 1'b1;
    #1;
    check("flush iaReady", iaReady, 0);
    cycle();
    flush = 1'b0;
    iaValid = 1'b1; iaPstate0 = 32'h99; iaPstate1 = 32'h2000;
    #1;
    check("kill iaReady", iaReady, 0);
    check("kill icReqValid", icReqValid, 0);
    check("kill fdValid", fdValid, 0);
    cycle();
    icRspValid = 1'b1; icRspData = 32'h1111_1111;
    #1;
    check("kill rsp iaReady", iaReady, 0);
    cycle();
    icRspValid = 1'b0;
    #1;
    check("drained iaReady", iaReady, 1);
    check("drained fdValid", fdValid, 0);
    cycle();
    iaValid = 1'b0;
    check("refetch icReqValid", icReqValid, 1);
    check("refetch icReqOfs", icReqOfs, 32'h2000);
    icReqReady = 1'b1; cycle();
    icReqReady = 1'b0; icRspValid = 1'b1; icRspData = 32'h2222_2222; cycle();
    icRspValid = 1'b0;
    check("refetch fdValid", fdValid, 1);
    check("refetch fdInstr", fdInstr, 32'h2222_2222);
    check("refetch fdPstate1", fdPstate1, 32'h2000);
    check("late response leak", leak_cnt, 0);
    cycle();

    // Misaligned offset.
    iaValid = 1'b1; iaPstate0 = 32'h55; iaPstate1 = 32'h1002;
    #1;
    check("align iaReady", iaReady, 1);
    cycle();
    iaValid = 1'b0; fdReady = 1'b0;
`ifdef VCPU32_FETCH_ALIGN_CHECK_EN
    check("align icReqValid", icReqValid, 0);
    check("align fdValid", fdValid, 1);
    check("align fdTrap", fdTrap, 2);
    check("align fdInstr", fdInstr, 0);
    check("align fdPstate1", fdPstate1, 32'h1002);
`else
    check("align icReqValid", icReqValid, 1);
    check("align icReqOfs", icReqOfs, 32'h1000);
    icReqReady = 1'b1; cycle();
    icReqReady = 1'b0; icRspValid = 1'b1; icRspData = 32'h1357_2468; cycle();
    icRspValid = 1'b0;
    check("align fdValid", fdValid, 1);
    check("align fdTrap", fdTrap, 0);
    check("align fdInstr", fdInstr, 32'h1357_2468);
    check("align fdPstate1", fdPstate1, 32'h1002);
`endif
    fdReady = 1'b1; cycle();

    // Reset while a killed response is still pending clears the kill flag.
    iaValid = 1'b1; iaPstate1 = 32'h6000; cycle();
    iaValid = 1'b0; icReqReady = 1'b1; cycle();
    icReqReady = 1'b0; flush = 1'b1; cycle();
    flush = 1'b0;
    check("pre-reset iaReady", iaReady, 0);
    rst = 1'b0; cycle();
    rst = 1'b1;
    #1;
    check("post-reset iaReady", iaReady, 1);
    check("post-reset fdValid", fdValid, 0);
    check("post-reset icReqOfs", icReqOfs, 0);
    check("post-reset fdInstr", fdInstr, 0);

    // Random traffic against the transaction-level model.
    m_have_addr = 0; m_in_flight = 0; m_orphan = 0; m_out_valid = 0;
    m_seg = '0; m_ofs = '0; m_instr = '0; m_p0 = '0; m_p1 = '0; m_trap = '0;
    pend = -1;
    for (int i = 0; i < 3000; i++) begin
      iaValid = ($urandom % 100) < 60;
      iaPstate0 = $urandom;
      r = $urandom;
      iaPstate1 = (($urandom % 4) == 0) ? r : (r & ~32'h3);
      icReqReady = $urandom % 2;
      flush = ($urandom % 100) < 6;
      fdReady = ($urandom % 100) < 65;
      icRspValid = (pend == 0);
      icRspData = $urandom;
      icRspErr = ($urandom % 8) == 0;
      #1;
      exp_rdy = !flush && ((!m_have_addr && !m_in_flight && !m_orphan && !m_out_valid) ||
                           (m_out_valid && fdReady));
      check("rnd iaReady", iaReady, exp_rdy);
      check("rnd icReqValid", icReqValid, m_have_addr);
      check("rnd icReqSeg", icReqSeg, m_seg);
`ifdef VCPU32_FETCH_ALIGN_CHECK_EN
      check("rnd icReqOfs", icReqOfs, m_ofs);
      mis = iaPstate1[1:0] != 2'b00;
`else
      check("rnd icReqOfs", icReqOfs, m_ofs & ~32'h3);
      mis = 1'b0;
`endif
      check("rnd fdValid", fdValid, m_out_valid);
      check("rnd fdInstr", fdInstr, m_instr);
      check("rnd fdPstate0", fdPstate0, m_p0);
      check("rnd fdPstate1", fdPstate1, m_p1);
      check("rnd fdTrap", fdTrap, m_trap);

      acc = exp_rdy && iaValid;
      hs = m_have_addr && icReqReady;
      n_have = m_have_addr; n_in = m_in_flight; n_orph = m_orphan; n_outv = m_out_valid;
      if (m_orphan && icRspValid) n_orph = 1'b0;
      if (flush) begin
        if ((m_in_flight && !icRspValid) || hs) n_orph = 1'b1;
        n_have = 1'b0; n_in = 1'b0; n_outv = 1'b0;
      end else begin
        if (m_out_valid && fdReady) n_outv = 1'b0;
        if (m_in_flight && icRspValid) begin
          n_in = 1'b0; n_outv = 1'b1;
          m_instr = icRspErr ? '0 : icRspData;
          m_p0 = m_seg; m_p1 = m_ofs;
          m_trap = icRspErr ? 2'd1 : 2'd0;
        end
        if (hs) begin
          n_have = 1'b0; n_in = 1'b1;
        end
        if (acc) begin
          if (mis) begin
            n_outv = 1'b1; m_instr = '0; m_p0 = iaPstate0; m_p1 = iaPstate1; m_trap = 2'd2;
          end else begin
            n_have = 1'b1;
          end
        end
      end
      if (acc) begin
        m_seg = iaPstate0; m_ofs = iaPstate1;
      end
      m_have_addr = n_have; m_in_flight = n_in; m_orphan = n_orph; m_out_valid = n_outv;
      if (pend == 0) pend = -1;
      else if (pend > 0) pend--;
      if (hs) pend = int'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch half of the FD pipeline stage.
- Accepts the next instruction address (pstate pair) from the instruction address stage and issues a read to the I-cache over a valid/ready request channel.
- Captures the returned instruction word and presents instruction plus pstate to decode with a valid/stall handshake.
- Handles pipeline flush and cache miss latency, and back-pressures the instruction address stage.

Parameters:
- WORD_LENGTH, 32, width of pstate words and instruction word.
- MAX_OUTSTANDING, 1, I-cache requests in flight; fixed at 1, kept for package consistency.

Ports:
- clk  in  1  stage clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- iaPstate0  in  WORD_LENGTH  pstate0 from the address stage: status bits and segment.
- iaPstate1  in  WORD_LENGTH  pstate1 from the address stage: instruction offset.
- iaValid  in  1  address stage presents a valid address.
- iaReady  out  1  fetch stage accepts the address this cycle.
- icReqValid  out  1  I-cache request valid.
- icReqReady  in  1  I-cache accepts the request.
- icReqSeg  out  WORD_LENGTH  segment = iaPstate0 latched.
- icReqOfs  out  WORD_LENGTH  offset = iaPstate1 latched.
- icRspValid  in  1  I-cache returns data.
- icRspData  in  WORD_LENGTH  instruction word.
- icRspErr  in  1  access/translation error.
- flush  in  1  redirect from MA/EX; kill all fetch state.
- fdReady  in  1  decode consumes the output this cycle.
- fdValid  out  1  output bundle valid.
- fdInstr  out  WORD_LENGTH  instruction word.
- fdPstate0  out  WORD_LENGTH  pstate0 of the instruction.
- fdPstate1  out  WORD_LENGTH  pstate1 of the instruction.
- fdTrap  out  2  00 none, 01 access error, 10 alignment; 11 reserved.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE.
  - fdValid=0, icReqValid=0, iaReady=1.
  - fdInstr, fdPstate0/1, icReqSeg/Ofs = 0; fdTrap=00.
  - Any in-flight cache response is dropped via the kill flag, cleared at reset.
- States:
  - IDLE: iaReady=1. On iaValid, latch pstates and go to REQ. icReqValid rises the cycle after acceptance (1-cycle address latch).
  - REQ: icReqValid=1, request fields stable until icReqReady. On the handshake, go to WAIT.
  - WAIT: on icRspValid, load fdInstr and set fdValid. On icRspErr, set fdTrap=01 and fdInstr=0. Go to OUT.
  - OUT: fdValid=1, outputs held stable while fdReady=0.
    - fdReady=1 with iaValid=1: accept the next address the same cycle (iaReady=1) and go to REQ.
    - fdReady=1 with iaValid=0: go to IDLE.
- iaReady=1 only in IDLE, or in OUT when fdReady=1. Never with flush=1.
- Best-case throughput: one instruction per 3 cycles on a hit (accept, request, response). There is no prefetch.
- flush=1 (highest priority):
  - Next state is IDLE, fdValid=0, icReqValid=0 next cycle.
  - If flush arrives in WAIT or in REQ after the handshake, set the kill flag. The next icRspValid is consumed and discarded, and new requests are held off until it arrives.
  - Flush and iaValid in the same cycle: the address is not accepted.
- Response arriving while not in WAIT and kill=0: protocol error. Ignore it; assertion in simulation.
- icRspValid in the same cycle as flush: discarded, kill not set.
- No arithmetic; the next offset is computed by the address stage.

Optional Feature:
- Macro: VCPU32_FETCH_ALIGN_CHECK_EN.
- Defined: in IDLE/OUT, an accepted address with iaPstate1[1:0]!=0 issues no cache request. The stage goes directly to OUT next cycle with fdTrap=10, fdInstr=0, and pstates latched.
- Undefined: offset bits [1:0] are forced to 0 on icReqOfs and never trap. Trap code 10 is unused.

Decomposition:
- Shared package (defines.vh): WORD_LENGTH, the fetch state enum (IDLE, REQ, WAIT, OUT), trap code constants (TRAP_NONE, TRAP_IACC, TRAP_ALIGN), and the pstate field positions for segment/offset.
- One natural sub-module: fetch_out_reg, the decode-side output register with hold-on-stall and clear-on-flush.
- Everything else stays in a single always block plus next-state logic.

Test Plan:
- Reset then hit: iaValid with pstate1=0x0000_1000, cache ready, response 0xDEADBEEF one cycle after the request → fdValid in cycle 3, fdInstr=0xDEADBEEF, fdPstate1=0x1000, fdTrap=00.
- Decode stall: hold fdReady=0 for 5 cycles → outputs stable, iaReady=0. Release → next address accepted the same cycle.
- Cache miss: icReqReady low for 4 cycles, then a response 6 cycles later → icReqOfs held constant throughout and exactly one request handshake.
- Flush in WAIT: then supply a new address 0x2000 and the late response 0x11111111 → late response discarded. fdInstr shows the response for 0x2000 and never 0x11111111.
- Access error: icRspErr=1 → fdTrap=01, fdInstr=0, fdValid=1.
- VCPU32_FETCH_ALIGN_CHECK_EN with pstate1=0x1002 → no icReqValid, fdTrap=10 next cycle. With the macro undefined → icReqOfs=0x1000.
